uart_tx_stage: RTL and testbench
================================

Name: uart_tx_stage

Overview:
- Downstream consumer of the 8-bit registered output byte. Serialises each accepted byte onto a single pin as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
- Placed in the top-level between the output register and one bidirectional pin driven as an output, so the chip can stream its result byte to a host at a fixed baud rate.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 = insert an even-parity bit between the data bits and the stop bit.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- data_in  input  8  byte to send; sampled only on acceptance.
- valid  input  1  producer requests transmission of data_in.
- ready  output  1  registered; high only while the block is idle and able to accept.
- tx  output  1  serial line; idle level 1.
- busy  output  1  registered; high from the cycle after acceptance until the frame completes.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the next state is tx=1, ready=1, busy=0, done=0, state=IDLE, bit and baud counters=0, shift register=0. Reset takes priority over every other event, including mid-frame; tx returns to 1 on that edge with no partial stop bit.
- Handshake: acceptance happens when valid=1 and ready=1 at a rising edge. On that edge the block captures data_in into the shift register, goes to START, and drops ready and raises busy. valid while ready=0 is ignored; nothing is queued. data_in changes after acceptance have no effect on the frame.
- States:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: bits 0..7 LSB first, each held CLKS_PER_BIT cycles; the bit index wraps from 7 to the next state.
  - PARITY: present only if PARITY_EN=1; tx = XOR of the 8 captured bits, held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing: tx first goes low on the edge of acceptance, visible in the cycle after it. Each bit lasts exactly CLKS_PER_BIT cycles. Baud counter counts 0..CLKS_PER_BIT-1 and advances the state on terminal count.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Completion: on the edge leaving STOP, ready=1, busy=0 and done=1 for exactly one cycle.
- Back-to-back: if valid is held high, the next acceptance occurs on the first edge where ready=1. The next start bit therefore begins 1 cycle after the previous stop bit ends (idle gap of exactly 1 cycle).
- tx and all outputs are registered; there is no combinational path from inputs to outputs.
- Counter width is $clog2(CLKS_PER_BIT); the counter must not overflow at the maximum parameter value.

Decomposition:
- Shared package uart_pkg:
  - state enum IDLE/START/DATA/PARITY/STOP (3-bit encoding);
  - DATA_BITS=8;
  - TX_IDLE=1'b1 constant.
- Sub-module baud_tick: counter with synchronous rst_n and a clear input; outputs a terminal-count pulse every CLKS_PER_BIT cycles while enabled.
- Top-level FSM, shift register and parity XOR live in uart_tx_stage.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, PARITY_EN=0; reset, then valid=1 with data_in=0xA5 for one cycle → tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total). busy high for 40 cycles, done pulses once, ready returns 1.
- Parity: PARITY_EN=1, data_in=0x07 → parity bit 1, frame 44 cycles; data_in=0x03 → parity bit 0.
- Back-to-back: valid held high with 0x00 then 0xFF → two frames separated by exactly one tx=1 idle cycle; two done pulses 41 cycles apart.
- Ignored request: valid=1 with 0x3C while busy, mid-frame → no change to the current frame; no second frame after done once valid is dropped.
- Reset mid-frame: rst_n=0 for one edge during DATA bit 3 → next cycle tx=1, ready=1, busy=0, done=0; a subsequent 0x55 transmits correctly.
- Minimum divider: CLKS_PER_BIT=2, data_in=0x81 → 20-cycle frame with correct bit timing and a single done pulse.

Source files
------------

// File: rtl/uart_tx_stage_pkg.sv
// Shared types and constants for the UART transmit stage.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic TX_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

  function automatic logic evenParity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_stage_if.sv
// Producer-side byte handshake plus serial line and status of the UART transmit stage.
interface uart_tx_stage_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] dataIn;
  logic                 valid;
  logic                 ready;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (output dataIn, valid, input ready, tx, busy, done);
  modport slave  (input dataIn, valid, output ready, tx, busy, done);
endinterface

// File: rtl/uart_tx_stage_baud_tick.sv
// Bit-period counter: tick pulses on the last cycle of every CLKS_PER_BIT window while enabled.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (en)         cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_stage.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_stage_if.slave bus
);
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gBadDiv
    $error("CLKS_PER_BIT out of range 2..65535");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  txState_e             state, nextState;
  logic [DATA_BITS-1:0] shiftReg;
  logic [2:0]           bitIdx;
  logic                 parityBit;
  logic                 txReg, readyReg, busyReg, doneReg;
  logic                 txNext, readyNext, busyNext, doneNext;
  logic                 accept, tick;

  assign accept = bus.valid && readyReg;

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) uBaud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = START;
      START:   if (tick) nextState = DATA;
      DATA:    if (tick && bitIdx == LAST_BIT) nextState = PARITY_EN ? PARITY : STOP;
      PARITY:  if (tick) nextState = STOP;
      STOP:    if (tick) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // tx is registered, so it is derived from the state being entered; within DATA
  // the bit about to be exposed is shiftReg[1] because the shift happens on the same edge.
  always_comb begin
    txNext    = txReg;
    readyNext = readyReg;
    busyNext  = busyReg;
    doneNext  = 1'b0;
    case (nextState)
      IDLE:    txNext = TX_IDLE;
      START:   txNext = 1'b0;
      DATA:    txNext = (state == DATA && tick) ? shiftReg[1] : shiftReg[0];
      PARITY:  txNext = parityBit;
      STOP:    txNext = 1'b1;
      default: txNext = TX_IDLE;
    endcase
    if (accept) begin
      readyNext = 1'b0;
      busyNext  = 1'b1;
    end else if (state == STOP && tick) begin
      readyNext = 1'b1;
      busyNext  = 1'b0;
      doneNext  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txReg     <= TX_IDLE;
      readyReg  <= 1'b1;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      shiftReg  <= '0;
      bitIdx    <= '0;
      parityBit <= 1'b0;
    end else begin
      txReg    <= txNext;
      readyReg <= readyNext;
      busyReg  <= busyNext;
      doneReg  <= doneNext;
      if (accept) begin
        shiftReg  <= bus.dataIn;
        parityBit <= evenParity(bus.dataIn);
        bitIdx    <= '0;
      end else if (state == DATA && tick) begin
        shiftReg <= shiftReg >> 1;
        bitIdx   <= (bitIdx == LAST_BIT) ? 3'd0 : bitIdx + 3'd1;
      end
    end
  end

  assign bus.tx    = txReg;
  assign bus.ready = readyReg;
  assign bus.busy  = busyReg;
  assign bus.done  = doneReg;
endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage: three instances cover divider 4, divider 4 with parity, divider 2.
module tb_uart_tx_stage;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_stage_if ifA();
  uart_tx_stage_if ifP();
  uart_tx_stage_if ifM();

  uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
  uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dutP (.clk(clk), .rst_n(rst_n), .bus(ifP.slave));
  uart_tx_stage #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) dutM (.clk(clk), .rst_n(rst_n), .bus(ifM.slave));

  int nChecks = 0;
  int nFails  = 0;
  logic txLog [0:127];
  logic busyLog [0:127];
  logic doneLog [0:127];
  logic readyLog [0:127];

  // Reference frame: bit period k/n -> start, data LSB first, optional parity, stop.
  function automatic logic expTx(input logic [7:0] d, input bit par, input int n, input int k);
    int pos;
    pos = k / n;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (par && pos == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic setReq(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0: begin ifA.valid = v; ifA.dataIn = d; end
      1: begin ifP.valid = v; ifP.dataIn = d; end
      default: begin ifM.valid = v; ifM.dataIn = d; end
    endcase
  endtask

  task automatic sample(input int sel, input int c);
    case (sel)
      0: begin txLog[c] = ifA.tx; busyLog[c] = ifA.busy; doneLog[c] = ifA.done; readyLog[c] = ifA.ready; end
      1: begin txLog[c] = ifP.tx; busyLog[c] = ifP.busy; doneLog[c] = ifP.done; readyLog[c] = ifP.ready; end
      default: begin txLog[c] = ifM.tx; busyLog[c] = ifM.busy; doneLog[c] = ifM.done; readyLog[c] = ifM.ready; end
    endcase
  endtask

  task automatic test_reset();
    logic [3:0] got;
    setReq(0, 1'b0, 8'h00); setReq(1, 1'b0, 8'h00); setReq(2, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sample(s, 0);
      got = {txLog[0], readyLog[0], busyLog[0], doneLog[0]};
      nChecks++;
      if (got !== 4'b1100) begin
        nFails++;
        $display("FAIL reset dut%0d {tx,ready,busy,done}: got %b expected 1100", s, got);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [9:0] pat = 10'b1101001010;
    int busyCnt = 0, readyLow = 0, doneCnt = 0;
    setReq(0, 1'b1, 8'hA5);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk); sample(0, c);
      if (c == 1) setReq(0, 1'b0, 8'h00);
    end
    for (int c = 1; c <= 40; c++) begin
      nChecks++;
      if (txLog[c] !== pat[(c-1)/4]) begin
        nFails++;
        $display("FAIL basic tx cyc %0d: got %b expected %b", c, txLog[c], pat[(c-1)/4]);
      end
      if (busyLog[c] === 1'b1) busyCnt++;
      if (readyLog[c] === 1'b0) readyLow++;
    end
    for (int c = 1; c <= 42; c++) if (doneLog[c] === 1'b1) doneCnt++;
    nChecks++;
    if (busyCnt != 40 || busyLog[41] !== 1'b0) begin
      nFails++; $display("FAIL basic busy: got %0d cycles (end %b) expected 40 (end 0)", busyCnt, busyLog[41]);
    end
    nChecks++;
    if (readyLow != 40 || readyLog[41] !== 1'b1) begin
      nFails++; $display("FAIL basic ready: got %0d low (end %b) expected 40 low (end 1)", readyLow, readyLog[41]);
    end
    nChecks++;
    if (doneCnt != 1 || doneLog[41] !== 1'b1) begin
      nFails++; $display("FAIL basic done: got %0d pulses (cyc41 %b) expected 1 at cyc41", doneCnt, doneLog[41]);
    end
    nChecks++;
    if (txLog[41] !== 1'b1 || txLog[42] !== 1'b1) begin
      nFails++; $display("FAIL basic idle tx: got %b%b expected 11", txLog[41], txLog[42]);
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [2] = '{8'h07, 8'h03};
    logic       parExp [2] = '{1'b1, 1'b0};
    int doneCnt;
    for (int b = 0; b < 2; b++) begin
      setReq(1, 1'b1, bytes[b]);
      for (int c = 1; c <= 46; c++) begin
        @(negedge clk); sample(1, c);
        if (c == 1) setReq(1, 1'b0, 8'h00);
      end
      for (int c = 1; c <= 44; c++) begin
        nChecks++;
        if (txLog[c] !== expTx(bytes[b], 1'b1, 4, c-1)) begin
          nFails++;
          $display("FAIL parity frame %02h tx cyc %0d: got %b expected %b", bytes[b], c, txLog[c], expTx(bytes[b], 1'b1, 4, c-1));
        end
      end
      nChecks++;
      if (txLog[37] !== parExp[b] || txLog[40] !== parExp[b]) begin
        nFails++; $display("FAIL parity bit %02h: got %b%b expected %b", bytes[b], txLog[37], txLog[40], parExp[b]);
      end
      doneCnt = 0;
      for (int c = 1; c <= 46; c++) if (doneLog[c] === 1'b1) doneCnt++;
      nChecks++;
      if (doneCnt != 1 || doneLog[45] !== 1'b1 || busyLog[44] !== 1'b1) begin
        nFails++; $display("FAIL parity length %02h: got done %0d (cyc45 %b) expected 1 at cyc45", bytes[b], doneCnt, doneLog[45]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int donePos [$];
    int idleBad = 0;
    setReq(0, 1'b1, 8'h00);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk); sample(0, c);
      if (c == 1)  setReq(0, 1'b1, 8'hFF);
      if (c == 42) setReq(0, 1'b0, 8'hFF);
    end
    for (int c = 1; c <= 40; c++) begin
      nChecks++;
      if (txLog[c] !== expTx(8'h00, 1'b0, 4, c-1)) begin
        nFails++; $display("FAIL b2b frame1 tx cyc %0d: got %b expected %b", c, txLog[c], expTx(8'h00, 1'b0, 4, c-1));
      end
    end
    nChecks++;
    if (txLog[41] !== 1'b1) begin
      nFails++; $display("FAIL b2b gap tx: got %b expected 1", txLog[41]);
    end
    for (int c = 42; c <= 81; c++) begin
      nChecks++;
      if (txLog[c] !== expTx(8'hFF, 1'b0, 4, c-42)) begin
        nFails++; $display("FAIL b2b frame2 tx cyc %0d: got %b expected %b", c, txLog[c], expTx(8'hFF, 1'b0, 4, c-42));
      end
    end
    for (int c = 1; c <= 90; c++) if (doneLog[c] === 1'b1) donePos.push_back(c);
    nChecks++;
    if (donePos.size() != 2 || donePos[0] != 41 || donePos[1] != 82) begin
      nFails++; $display("FAIL b2b done: got %0d pulses first %0d expected 2 at 41 and 82",
                         donePos.size(), (donePos.size() > 0) ? donePos[0] : -1);
    end
    for (int c = 83; c <= 90; c++) if (txLog[c] !== 1'b1 || readyLog[c] !== 1'b1) idleBad++;
    nChecks++;
    if (idleBad != 0) begin
      nFails++; $display("FAIL b2b trailing idle: got %0d bad cycles expected 0", idleBad);
    end
  endtask

  task automatic test_ignored();
    int doneCnt = 0, idleBad = 0;
    setReq(0, 1'b1, 8'hC3);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk); sample(0, c);
      if (c == 1)  setReq(0, 1'b0, 8'h00);
      if (c == 10) setReq(0, 1'b1, 8'h3C);
      if (c == 30) setReq(0, 1'b0, 8'h3C);
    end
    for (int c = 1; c <= 40; c++) begin
      nChecks++;
      if (txLog[c] !== expTx(8'hC3, 1'b0, 4, c-1)) begin
        nFails++; $display("FAIL ignored tx cyc %0d: got %b expected %b", c, txLog[c], expTx(8'hC3, 1'b0, 4, c-1));
      end
    end
    for (int c = 1; c <= 60; c++) if (doneLog[c] === 1'b1) doneCnt++;
    nChecks++;
    if (doneCnt != 1 || doneLog[41] !== 1'b1) begin
      nFails++; $display("FAIL ignored done: got %0d pulses expected 1 at cyc41", doneCnt);
    end
    for (int c = 42; c <= 60; c++) if (txLog[c] !== 1'b1 || busyLog[c] !== 1'b0) idleBad++;
    nChecks++;
    if (idleBad != 0) begin
      nFails++; $display("FAIL ignored second frame: got %0d non-idle cycles expected 0", idleBad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    int doneCnt = 0;
    setReq(0, 1'b1, 8'hF0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk); sample(0, c);
      if (c == 1) setReq(0, 1'b0, 8'h00);
    end
    nChecks++;
    if (txLog[18] !== 1'b0 || busyLog[18] !== 1'b1) begin
      nFails++; $display("FAIL midreset pre tx/busy: got %b%b expected 01", txLog[18], busyLog[18]);
    end
    rst_n = 1'b0;
    @(negedge clk); sample(0, 19);
    rst_n = 1'b1;
    got = {txLog[19], readyLog[19], busyLog[19], doneLog[19]};
    nChecks++;
    if (got !== 4'b1100) begin
      nFails++; $display("FAIL midreset {tx,ready,busy,done}: got %b expected 1100", got);
    end
    for (int c = 20; c <= 30; c++) begin
      @(negedge clk); sample(0, c);
      if (doneLog[c] === 1'b1 || txLog[c] !== 1'b1) doneCnt++;
    end
    nChecks++;
    if (doneCnt != 0) begin
      nFails++; $display("FAIL midreset aftermath: got %0d bad cycles expected 0", doneCnt);
    end
    setReq(0, 1'b1, 8'h55);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk); sample(0, c);
      if (c == 1) setReq(0, 1'b0, 8'h00);
    end
    for (int c = 1; c <= 40; c++) begin
      nChecks++;
      if (txLog[c] !== expTx(8'h55, 1'b0, 4, c-1)) begin
        nFails++; $display("FAIL midreset 55 tx cyc %0d: got %b expected %b", c, txLog[c], expTx(8'h55, 1'b0, 4, c-1));
      end
    end
    nChecks++;
    if (doneLog[41] !== 1'b1 || doneLog[42] !== 1'b0) begin
      nFails++; $display("FAIL midreset 55 done: got %b%b expected 10", doneLog[41], doneLog[42]);
    end
  endtask

  task automatic test_min_divider();
    int doneCnt = 0, busyCnt = 0;
    setReq(2, 1'b1, 8'h81);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk); sample(2, c);
      if (c == 1) setReq(2, 1'b0, 8'h00);
    end
    for (int c = 1; c <= 20; c++) begin
      nChecks++;
      if (txLog[c] !== expTx(8'h81, 1'b0, 2, c-1)) begin
        nFails++; $display("FAIL mindiv tx cyc %0d: got %b expected %b", c, txLog[c], expTx(8'h81, 1'b0, 2, c-1));
      end
    end
    for (int c = 1; c <= 22; c++) begin
      if (doneLog[c] === 1'b1) doneCnt++;
      if (busyLog[c] === 1'b1) busyCnt++;
    end
    nChecks++;
    if (doneCnt != 1 || doneLog[21] !== 1'b1 || busyCnt != 20) begin
      nFails++; $display("FAIL mindiv done/busy: got done %0d busy %0d expected 1 and 20", doneCnt, busyCnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_ignored();
    test_reset_mid_frame();
    test_min_divider();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
